// File: rtl/sample_capture_buffer_if.sv
// Bus bundle for sample_capture_buffer: sample input, capture control, readout.
// trig_falling exists only when SAMPLE_CAPTURE_SLOPE_EN is defined.
interface sample_capture_buffer_if #(
  parameter int X_WIDTH    = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                         sample_valid;
  logic signed [X_WIDTH-1:0]    x;
  logic                         arm;
  logic        [ADDR_WIDTH-1:0] pretrig;
  logic signed [X_WIDTH-1:0]    trig_level;
  logic                         rd_en;
`ifdef SAMPLE_CAPTURE_SLOPE_EN
  logic                         trig_falling;
`endif
  logic        [2:0]            state;
  logic                         done;
  logic signed [X_WIDTH-1:0]    rd_data;
  logic                         rd_valid;

  modport master (
    output sample_valid, x, arm, pretrig, trig_level, rd_en,
`ifdef SAMPLE_CAPTURE_SLOPE_EN
    output trig_falling,
`endif
    input  state, done, rd_data, rd_valid
  );

  modport slave (
    input  sample_valid, x, arm, pretrig, trig_level, rd_en,
`ifdef SAMPLE_CAPTURE_SLOPE_EN
    input  trig_falling,
`endif
    output state, done, rd_data, rd_valid
  );
endinterface

// File: rtl/sample_capture_buffer.sv
// Pre/post-trigger capture of a decimated sample stream into a circular buffer.
// Define SAMPLE_CAPTURE_SLOPE_EN to add a selectable falling-edge trigger.
module sample_capture_buffer #(
  parameter int X_WIDTH    = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  sample_capture_buffer_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_WAIT    = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                    r_state, w_state_next;
  logic signed [X_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]     r_wp, r_idx, r_ta, r_pre;
  logic [CW-1:0]             r_cnt;
  logic signed [X_WIDTH-1:0] r_lvl, r_prev, r_rd_data;
  logic                      r_have_prev, r_rd_valid;

  logic signed [X_WIDTH-1:0] w_x;
  logic [ADDR_WIDTH-1:0]     w_pre_clamped, w_wp_inc, w_idx_inc, w_rd_addr;
  logic [CW-1:0]             w_cnt_inc, w_post_len;
  logic                      w_arm_ok, w_store, w_trig, w_rd;

  assign w_x           = bus.x;
  assign w_pre_clamped = (bus.pretrig > LAST) ? LAST : bus.pretrig;
  assign w_wp_inc      = (r_wp == LAST) ? '0 : r_wp + 1'b1;
  assign w_idx_inc     = (r_idx == LAST) ? '0 : r_idx + 1'b1;
  assign w_rd_addr     = (r_ta - r_pre + r_idx) & LAST;
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_post_len    = CW'(DEPTH) - {1'b0, r_pre};
  assign w_arm_ok      = bus.arm && (r_state == S_IDLE || r_state == S_DONE);
  assign w_store       = bus.sample_valid &&
                         (r_state == S_PREFILL || r_state == S_WAIT || r_state == S_POST);
  // arm takes priority over a simultaneous read request
  assign w_rd          = bus.rd_en && !bus.arm && (r_state == S_DONE);

`ifdef SAMPLE_CAPTURE_SLOPE_EN
  logic r_fall;
  assign w_trig = r_have_prev && (r_fall ? ((r_prev > r_lvl) && (w_x <= r_lvl))
                                         : ((r_prev < r_lvl) && (w_x >= r_lvl)));
`else
  assign w_trig = r_have_prev && (r_prev < r_lvl) && (w_x >= r_lvl);
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE:
        if (bus.arm) w_state_next = (w_pre_clamped == '0) ? S_WAIT : S_PREFILL;
      S_PREFILL:
        if (bus.sample_valid && w_cnt_inc == {1'b0, r_pre}) w_state_next = S_WAIT;
      S_WAIT:
        if (bus.sample_valid && w_trig)
          w_state_next = (w_post_len == CW'(1)) ? S_DONE : S_POST;
      S_POST:
        if (bus.sample_valid && w_cnt_inc == w_post_len) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wp] <= w_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp        <= '0;
      r_idx       <= '0;
      r_ta        <= '0;
      r_pre       <= '0;
      r_cnt       <= '0;
      r_lvl       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
`ifdef SAMPLE_CAPTURE_SLOPE_EN
      r_fall      <= 1'b0;
`endif
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= r_mem[w_rd_addr];
        r_idx     <= w_idx_inc;
      end
      if (w_arm_ok) begin
        r_wp        <= '0;
        r_cnt       <= '0;
        r_idx       <= '0;
        r_pre       <= w_pre_clamped;
        r_lvl       <= bus.trig_level;
        r_have_prev <= 1'b0;
`ifdef SAMPLE_CAPTURE_SLOPE_EN
        r_fall      <= bus.trig_falling;
`endif
      end else if (w_store) begin
        r_wp        <= w_wp_inc;
        r_prev      <= w_x;
        r_have_prev <= 1'b1;
        // in WAIT the counter restarts at the trigger, counting it as the first post sample
        if (r_state == S_WAIT) begin
          if (w_trig) begin
            r_ta  <= r_wp;
            r_cnt <= CW'(1);
          end
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign bus.state    = r_state;
  assign bus.done     = (r_state == S_DONE);
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed bench for sample_capture_buffer; expected readouts are queued at stimulus time.
module tb_sample_capture_buffer;
  localparam int XW = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_capture_buffer_if #(.X_WIDTH(XW), .ADDR_WIDTH(AW)) ifc();

  sample_capture_buffer #(.X_WIDTH(XW), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    ifc.sample_valid = 1'b1;
    ifc.x            = XW'(v);
    tick();
    ifc.sample_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic arm_cap(input int pre, input int lvl);
    ifc.pretrig    = AW'(pre);
    ifc.trig_level = XW'(lvl);
    ifc.arm        = 1'b1;
    tick();
    ifc.arm        = 1'b0;
  endtask

  task automatic readout(input string tag, input int n);
    int expv;
    for (int i = 0; i < n; i++) begin
      ifc.rd_en = 1'b1;
      tick();
      ifc.rd_en = 1'b0;
      chk({tag, "_rd_valid"}, int'(ifc.rd_valid), 1);
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
      chk({tag, "_rd_data"}, int'(ifc.rd_data), expv);
      $display("read %s[%0d] data=%0d expected=%0d", tag, i, int'(ifc.rd_data), expv);
    end
    tick();
    chk({tag, "_rd_idle"}, int'(ifc.rd_valid), 0);
  endtask

  initial begin
    ifc.sample_valid = 1'b0;
    ifc.x            = '0;
    ifc.arm          = 1'b0;
    ifc.pretrig      = '0;
    ifc.trig_level   = '0;
    ifc.rd_en        = 1'b0;
`ifdef SAMPLE_CAPTURE_SLOPE_EN
    ifc.trig_falling = 1'b0;
`endif
    tick();
    tick();
    chk("rst_state", int'(ifc.state), 0);
    chk("rst_done", int'(ifc.done), 0);
    chk("rst_rd_valid", int'(ifc.rd_valid), 0);
    chk("rst_rd_data", int'(ifc.rd_data), 0);
    rst = 1'b0;
    tick();

    // zero pretrig: IDLE straight to WAIT, trigger at 3, readout 3..18 then idx wraps
    arm_cap(0, 3);
    chk("zp_state_wait", int'(ifc.state), 2);
    for (int v = -8; v <= 18; v++) begin
      send(v);
      if (v == 2)  chk("zp_pre_trig", int'(ifc.state), 2);
      if (v == 3)  chk("zp_post", int'(ifc.state), 3);
      if (v == 17) chk("zp_post_end", int'(ifc.state), 3);
    end
    chk("zp_done", int'(ifc.done), 1);
    for (int v = 3; v <= 18; v++) exp_q.push_back(v);
    exp_q.push_back(3);
    readout("zp", 17);

    // basic capture: pretrig 4, level 0, ramp from -8
    arm_cap(4, 0);
    chk("bc_prefill", int'(ifc.state), 1);
    for (int v = -8; v <= 11; v++) begin
      send(v);
      if (v == -6) chk("bc_still_prefill", int'(ifc.state), 1);
      if (v == -5) chk("bc_wait", int'(ifc.state), 2);
      if (v == -1) chk("bc_no_trig", int'(ifc.state), 2);
      if (v == 0)  chk("bc_trig", int'(ifc.state), 3);
      if (v == 10) chk("bc_post", int'(ifc.state), 3);
    end
    chk("bc_done_state", int'(ifc.state), 4);
    chk("bc_done", int'(ifc.done), 1);
    for (int v = -4; v <= 11; v++) exp_q.push_back(v);
    readout("bc", 16);

    // arm with rd_en in DONE: arm wins, no read
    ifc.pretrig    = AW'(4);
    ifc.trig_level = XW'(0);
    ifc.arm        = 1'b1;
    ifc.rd_en      = 1'b1;
    tick();
    ifc.arm        = 1'b0;
    ifc.rd_en      = 1'b0;
    chk("ig_arm_rd_state", int'(ifc.state), 1);
    chk("ig_arm_rd_valid", int'(ifc.rd_valid), 0);
    for (int v = -8; v <= -5; v++) send(v);
    chk("ig_wait", int'(ifc.state), 2);
    ifc.rd_en = 1'b1;
    tick();
    ifc.rd_en = 1'b0;
    chk("ig_rd_before_done", int'(ifc.rd_valid), 0);
    // arm in WAIT must not relatch pretrig 0 or level 100
    arm_cap(0, 100);
    chk("ig_arm_in_wait", int'(ifc.state), 2);
    for (int v = -4; v <= 11; v++) send(v);
    chk("ig_done", int'(ifc.state), 4);
    for (int v = -4; v <= 11; v++) exp_q.push_back(v);
    readout("ig", 16);

    // maximum pretrig with buffer wrap; DONE entered on the trigger sample
    arm_cap(15, 5);
    chk("mp_prefill", int'(ifc.state), 1);
    for (int i = 0; i < 15; i++) send(-1);
    chk("mp_wait", int'(ifc.state), 2);
    for (int i = 0; i < 40; i++) send(-1);
    chk("mp_still_wait", int'(ifc.state), 2);
    send(5);
    chk("mp_done_state", int'(ifc.state), 4);
    chk("mp_done", int'(ifc.done), 1);
    for (int i = 0; i < 15; i++) exp_q.push_back(-1);
    exp_q.push_back(5);
    readout("mp", 16);

    // asynchronous reset mid-POST abandons the capture
    arm_cap(4, 0);
    for (int v = -8; v <= 2; v++) send(v);
    chk("rs_in_post", int'(ifc.state), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_state", int'(ifc.state), 0);
    chk("rs_done", int'(ifc.done), 0);
    chk("rs_rd_valid", int'(ifc.rd_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    send(7);
    chk("rs_stays_idle", int'(ifc.state), 0);

`ifdef SAMPLE_CAPTURE_SLOPE_EN
    // falling slope: the rising crossing -2 -> 4 must not trigger
    ifc.trig_falling = 1'b1;
    arm_cap(0, 0);
    ifc.trig_falling = 1'b0;
    send(-2);
    send(4);
    chk("fs_no_rising", int'(ifc.state), 2);
    send(2);
    chk("fs_above", int'(ifc.state), 2);
    send(0);
    chk("fs_trig", int'(ifc.state), 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
